// File: rtl/fp_addsub_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fp_addsub_seq                                              |
// | Description : Multi-cycle IEEE-754 adder/subtractor, round-to-nearest-   |
// |               even, flush-to-zero, {invalid, overflow, inexact} flags,   |
// |               valid/ready handshakes, one operation in flight.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fp_addsub_seq #(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     op,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     result,
  output logic [2:0]               flags
);
  localparam int c_W   = 1 + EXP_W + MAN_W;
  localparam int c_DW  = MAN_W + 4;           // hidden + fraction + guard/round/sticky
  localparam int c_EW  = EXP_W + 2;           // headroom for carry and LZC underflow
  localparam int c_LZW = $clog2(c_DW);
  localparam logic [EXP_W-1:0] c_SH_MAX = EXP_W'(MAN_W + 3);
  localparam logic [c_EW-1:0]  c_EMAX   = {2'b00, {EXP_W{1'b1}}};
  localparam logic [c_W-1:0]   c_QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_ROUND = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            r_state, w_next;
  logic [c_W-1:0]    r_a, r_b;
  logic              r_special;
  logic [c_W-1:0]    r_spec_res;
  logic [2:0]        r_spec_flg;
  logic [c_DW-1:0]   r_ma, r_mb;
  logic              r_sub, r_sign, r_zero;
  logic [c_EW-1:0]   r_exp;
  logic [c_DW:0]     r_sum;
  logic [c_DW-1:0]   r_mant;
  logic [c_W-1:0]    r_result;
  logic [2:0]        r_flags;

  // ---------------- ALIGN: unpack, classify, swap, align ----------------
  logic              w_sa, w_sb;
  logic [EXP_W-1:0]  w_ea, w_eb;
  logic [MAN_W-1:0]  w_fa, w_fb;
  logic              w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_a_snan, w_b_snan;
  logic              w_swap;
  logic [EXP_W-1:0]  w_e_big, w_e_small, w_diff;
  logic [MAN_W-1:0]  w_f_big, w_f_small;
  logic [c_DW-1:0]   w_m_big, w_m_small, w_m_al;
  logic              w_lost;
  logic              w_special;
  logic [c_W-1:0]    w_spec_res;
  logic [2:0]        w_spec_flg;

  assign {w_sa, w_ea, w_fa} = r_a;
  assign {w_sb, w_eb, w_fb} = r_b;
  assign w_a_zero  = (w_ea == '0);
  assign w_b_zero  = (w_eb == '0);
  assign w_a_inf   = (w_ea == '1) && (w_fa == '0);
  assign w_b_inf   = (w_eb == '1) && (w_fb == '0);
  assign w_a_nan   = (w_ea == '1) && (w_fa != '0);
  assign w_b_nan   = (w_eb == '1) && (w_fb != '0);
  assign w_a_snan  = w_a_nan && !w_fa[MAN_W-1];
  assign w_b_snan  = w_b_nan && !w_fb[MAN_W-1];
  assign w_swap    = (r_b[c_W-2:0] > r_a[c_W-2:0]);
  assign w_e_big   = w_swap ? w_eb : w_ea;
  assign w_e_small = w_swap ? w_ea : w_eb;
  assign w_f_big   = w_swap ? w_fb : w_fa;
  assign w_f_small = w_swap ? w_fa : w_fb;
  assign w_diff    = w_e_big - w_e_small;
  assign w_m_big   = {1'b1, w_f_big, 3'b000};
  assign w_m_small = {1'b1, w_f_small, 3'b000};
  assign w_lost    = |(w_m_small & ~({c_DW{1'b1}} << w_diff));

  // Align the smaller operand; everything shifted out collapses into sticky
  always_comb begin
    w_m_al = (w_m_small >> w_diff) | {{(c_DW-1){1'b0}}, w_lost};
    if (w_diff >= c_SH_MAX) w_m_al = {{(c_DW-1){1'b0}}, 1'b1};
  end

  // Operands that bypass the arithmetic path (NaN, inf, zero/subnormal)
  always_comb begin
    w_special  = 1'b1;
    w_spec_res = '0;
    w_spec_flg = 3'b000;
    if (w_a_nan || w_b_nan) begin
      w_spec_res = c_QNAN;
      w_spec_flg = {w_a_snan || w_b_snan, 2'b00};
    end else if (w_a_inf && w_b_inf) begin
      if (w_sa == w_sb) w_spec_res = r_a;
      else begin
        w_spec_res = c_QNAN;
        w_spec_flg = 3'b100;
      end
    end else if (w_a_inf) w_spec_res = r_a;
    else if (w_b_inf)  w_spec_res = r_b;
    else if (w_a_zero && w_b_zero) w_spec_res = {w_sa & w_sb, {(c_W-1){1'b0}}};
    else if (w_a_zero) w_spec_res = r_b;
    else if (w_b_zero) w_spec_res = r_a;
    else w_special = 1'b0;
  end

  // ---------------- ADD / NORM ----------------
  logic [c_DW:0]     w_sum_n;
  logic [c_LZW-1:0]  w_lzc;
  logic [c_DW-1:0]   w_mant_n;
  logic [c_EW-1:0]   w_exp_n;

  // Swap guarantees the subtraction never goes negative
  assign w_sum_n = r_sub ? ({1'b0, r_ma} - {1'b0, r_mb}) : ({1'b0, r_ma} + {1'b0, r_mb});

  // Leading-zero count of the non-carry part of the sum
  always_comb begin
    w_lzc = '0;
    for (int i = 0; i < c_DW; i++) begin
      if (r_sum[i]) w_lzc = c_LZW'(c_DW - 1 - i);
    end
  end

  // Single-cycle normalisation: right by one on carry, else left by LZC
  always_comb begin
    if (r_sum[c_DW]) begin
      w_mant_n = {r_sum[c_DW:2], r_sum[1] | r_sum[0]};
      w_exp_n  = r_exp + {{(c_EW-1){1'b0}}, 1'b1};
    end else begin
      w_mant_n = r_sum[c_DW-1:0] << w_lzc;
      w_exp_n  = r_exp - {{(c_EW-c_LZW){1'b0}}, w_lzc};
    end
  end

  // ---------------- ROUND / pack ----------------
  logic              w_rup, w_inx;
  logic [MAN_W+1:0]  w_m_rnd;
  logic [c_EW-1:0]   w_e_rnd;
  logic [MAN_W-1:0]  w_f_rnd;
  logic [c_W-1:0]    w_res_n;
  logic [2:0]        w_flg_n;

  assign w_inx   = |r_mant[2:0];
  assign w_rup   = r_mant[2] & (r_mant[1] | r_mant[0] | r_mant[3]);
  assign w_m_rnd = {1'b0, r_mant[c_DW-1:3]} + {{(MAN_W+1){1'b0}}, w_rup};
  assign w_e_rnd = r_exp + {{(c_EW-1){1'b0}}, w_m_rnd[MAN_W+1]};
  assign w_f_rnd = w_m_rnd[MAN_W+1] ? w_m_rnd[MAN_W:1] : w_m_rnd[MAN_W-1:0];

  // Final result selection: bypass, cancellation, underflow, overflow, normal
  always_comb begin
    w_res_n = {r_sign, w_e_rnd[EXP_W-1:0], w_f_rnd};
    w_flg_n = {2'b00, w_inx};
    if (r_special) begin
      w_res_n = r_spec_res;
      w_flg_n = r_spec_flg;
    end else if (r_zero) begin
      w_res_n = '0;
      w_flg_n = 3'b000;
    end else if (r_exp[c_EW-1] || (r_exp == '0)) begin
      w_res_n = {r_sign, {(c_W-1){1'b0}}};
      w_flg_n = 3'b001;
    end else if (!w_e_rnd[c_EW-1] && (w_e_rnd >= c_EMAX)) begin
      w_res_n = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_flg_n = 3'b011;
    end
  end

  // ---------------- control ----------------
  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: fixed walk through the pipeline stages, handshakes at the ends
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_ALIGN;
      S_ALIGN: w_next = S_ADD;
      S_ADD:   w_next = S_NORM;
      S_NORM:  w_next = S_ROUND;
      S_ROUND: w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath registers, each stage loads only while the FSM sits in it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0; r_b <= '0;
      r_special <= 1'b0; r_spec_res <= '0; r_spec_flg <= 3'b000;
      r_ma <= '0; r_mb <= '0; r_sub <= 1'b0; r_sign <= 1'b0; r_exp <= '0;
      r_sum <= '0; r_mant <= '0; r_zero <= 1'b0;
      r_result <= '0; r_flags <= 3'b000;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_a <= a;
          r_b <= {b[c_W-1] ^ op, b[c_W-2:0]};
        end
        S_ALIGN: begin
          r_special  <= w_special;
          r_spec_res <= w_spec_res;
          r_spec_flg <= w_spec_flg;
          r_ma       <= w_m_big;
          r_mb       <= w_m_al;
          r_sub      <= w_sa ^ w_sb;
          r_sign     <= w_swap ? w_sb : w_sa;
          r_exp      <= {2'b00, w_e_big};
        end
        S_ADD:   r_sum <= w_sum_n;
        S_NORM: begin
          r_mant <= w_mant_n;
          r_exp  <= w_exp_n;
          r_zero <= (r_sum == '0);
        end
        S_ROUND: begin
          r_result <= w_res_n;
          r_flags  <= w_flg_n;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign flags     = r_flags;

endmodule
`default_nettype wire
